// File: rtl/ldr_pkg.sv
`default_nettype none
// ============================================================================
// Module : ldr_pkg
// Shared state encoding and register-bank geometry for the load writeback path.
// Rev    : 1.0
// ============================================================================
package ldr_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ldr_writeback_ctrl_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module : onehot_dec
// 4-to-16 combinational one-hot decoder producing the bank enable pattern.
// Rev    : 1.0
// ============================================================================
module onehot_dec
  import ldr_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx_i,
  output logic [NUM_REGS-1:0]  dec_o
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    assign dec_o[i] = (idx_i == REG_IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/ldr_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ldr_writeback_ctrl
// Single-word load sequencer driving the register bank's one-hot write enable.
// Rev    : 1.0
// ============================================================================
module ldr_writeback_ctrl
  import ldr_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_rd,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [15:0]         enable,
  output logic [DATA_W-1:0]   ldr_data,
  output logic                busy,
  output logic                err_timeout
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                 state_q;
  logic [REG_IDX_W-1:0]   rd_q;
  logic [15:0]            cnt_q;
  logic                   req_ready_q;
  logic                   mem_rd_en_q;
  logic                   busy_q;
  logic                   err_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      ldr_data_q;
  logic [NUM_REGS-1:0]    enable_q;
  logic [NUM_REGS-1:0]    enable_d;

  onehot_dec u_dec (
    .idx_i (rd_q),
    .dec_o (enable_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      ldr_data_q  <= '0;
      enable_q    <= '0;
    end else begin
      // The enable is a single-cycle pulse; every state but the READ->WRITE
      // transition leaves it cleared.
      enable_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            rd_q        <= req_rd;
            mem_addr_q  <= req_addr;
            mem_rd_en_q <= 1'b1;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end
        READ: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (mem_ack) begin
            ldr_data_q  <= mem_rdata;
            mem_rd_en_q <= 1'b0;
            enable_q    <= enable_d;
            state_q     <= WRITE;
          end else if (cnt_q == TO_LAST) begin
            mem_rd_en_q <= 1'b0;
            err_q       <= 1'b1;
            state_q     <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WRITE: begin
          state_q <= GAP;
        end
        GAP: begin
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign enable      = enable_q;
  assign ldr_data    = ldr_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ldr_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ldr_writeback_ctrl
// Scoreboard bench: driver queues expected bank events, monitor pops/compares.
// Rev    : 1.0
// ============================================================================
module tb_ldr_writeback_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 12;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       enable;
  logic [DATA_W-1:0] ldr_data;
  logic              busy;
  logic              err_timeout;

  ldr_writeback_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_addr    (req_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .enable      (enable),
    .ldr_data    (ldr_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bank-side outcome of one accepted request.
  typedef struct {
    bit          is_wr;
    logic [3:0]  rd;
    logic [31:0] data;
    int          len;   // number of cycles mem_rd_en must stay high
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_addr  = '0;
  logic [31:0] last_data = '0;   // value the bank register write last carried

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int run      = 0;
  int ph       = 0;
  bit prev_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run       = 0;
      ph        = 0;
      prev_err  = 1'b0;
      last_data = '0;
    end else begin
      if (ph == 2) begin
        chk("gap_enable", enable, 16'h0);
        chk("gap_state", {busy, req_ready}, 2'b10);
        chk("gap_ldr_hold", ldr_data, last_data);
        ph = 1;
      end else if (ph == 1) begin
        chk("back_to_idle", {busy, req_ready}, 2'b01);
        ph = 0;
      end

      if (enable != 16'h0 || (err_timeout && !prev_err)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {enable, 15'd0, err_timeout}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_en_cycles", run, e.len);
          if (e.is_wr) begin
            chk("enable_onehot", enable, 16'h1 << e.rd);
            chk("ldr_data", ldr_data, e.data);
            last_data = e.data;
            ph = 2;
          end else begin
            chk("timeout_no_write", enable, 16'h0);
            chk("timeout_state", {busy, req_ready, mem_rd_en}, 3'b100);
            ph = 1;
          end
        end
        run = 0;
      end

      if (mem_rd_en) begin
        run++;
        chk("mem_addr_stable", mem_addr, cur_addr);
      end
      prev_err = err_timeout;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk(name, 0, 1);
  endtask

  // w < 0: memory never answers (timeout); otherwise ack arrives after w wait cycles.
  task automatic txn(input logic [3:0] rd, input logic [31:0] addr,
                     input logic [31:0] data, input int w);
    exp_t e;
    e.is_wr = (w >= 0);
    e.rd    = rd;
    e.data  = data;
    e.len   = (w >= 0) ? w + 1 : TIMEOUT;
    wait_ready("ready_before_req");
    exp_q.push_back(e);
    cur_addr  = addr;
    req_rd    = rd;
    req_addr  = addr;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("accept_clears_err", {busy, err_timeout, mem_rd_en}, 3'b101);
    if (w >= 0) begin
      repeat (w) begin
        @(posedge clk); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    wait_ready("ready_after_txn");
  endtask

  task automatic stray_ack();
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    @(posedge clk); #1;
    chk("stray_ack_ldr_hold", ldr_data, last_data);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rd    = '0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {req_ready, mem_rd_en, busy, err_timeout, enable}, {4'b1000, 16'h0});
    chk("reset_data", {mem_addr, ldr_data}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(4'd5, 32'h100, 32'hDEADBEEF, 0);
    txn(4'd15, 32'h200, 32'h1, 0);
    txn(4'd15, 32'h204, 32'h2, 0);
    chk("final_bank_value", last_data, 32'h2);
    txn(4'd3, 32'h300, 32'hCAFE0003, 10);
    txn(4'd9, 32'h400, 32'h0, -1);
    chk("err_sticky", err_timeout, 1'b1);
    txn(4'd1, 32'h404, 32'h11, 0);
    txn(4'd2, 32'h408, 32'h22, TIMEOUT - 1);   // ack on the last allowed cycle wins

    for (int r = 0; r < 16; r++) begin
      stray_ack();
      txn(4'(r), 32'h1000 + 32'(r * 4), 32'(r) * 32'h11111111, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a read aborts without a write.
    wait_ready("ready_before_abort");
    cur_addr  = 32'h5000;
    req_rd    = 4'd7;
    req_addr  = 32'h5000;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {enable, mem_rd_en, req_ready, busy}, {16'h0, 3'b010});
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_write", {enable, busy}, 17'h0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) stray_ack();
      txn(4'($urandom_range(0, 15)), $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
